// File: rtl/memory_1_pkg.sv
// Shared constants for the memory_1 scratch RAM: default geometry and request encodings.
package memory_1_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

endpackage

// File: rtl/memory_1.sv
// Single-port synchronous scratch RAM with a valid/ready request interface and one-cycle read latency.
// Optional: define MEMORY_1_CLR_ON_RST_EN to zero every word while reset is asserted.
module memory_1
    import memory_1_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  rd_wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [WIDTH-1:0]      rdata_o,
    input  logic [WIDTH-1:0]      wdata_i
);

    // Kept as a plain unpacked array so benches can reach it hierarchically.
    reg [WIDTH-1:0] mem1 [DEPTH-1:0];

    logic accept;
    logic in_range;
    logic wr_en;
    logic rd_en;

    assign accept   = (valid_i == 1'b1) && ready_o && !rst_i;
    assign in_range = {1'b0, addr_i} < (ADDR_WIDTH + 1)'(DEPTH);
    assign wr_en    = accept && (rd_wr_i == WR) && in_range;
    assign rd_en    = accept && (rd_wr_i == RD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            ready_o <= 1'b1;
            if (rd_en) begin
                rdata_o <= in_range ? mem1[addr_i] : '0;
            end
        end
    end

`ifdef MEMORY_1_CLR_ON_RST_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] <= '0;
            end
        end else if (wr_en) begin
            mem1[addr_i] <= wdata_i;
        end
    end
`else
    // No reset on the array so backdoor preloads survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem1[addr_i] <= wdata_i;
        end
    end
`endif

    a_valid_known: assert property (@(posedge clk_i) disable iff (rst_i)
        ready_o |-> !$isunknown(valid_i))
        else $error("memory_1: valid_i is X/Z while ready_o is high");

    a_addr_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && ready_o) |-> in_range)
        else $warning("memory_1: address %0d out of range (DEPTH=%0d)", addr_i, DEPTH);

endmodule

// File: tb/tb_memory_1.sv
// Self-checking bench for memory_1: reference array plus a queue of expected read data.
module tb_memory_1;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       ready;
    logic       rd_wr;
    logic [3:0] addr;
    logic [7:0] rdata;
    logic [7:0] wdata;

    int checks;
    int errors;

    logic [7:0] mdl [16];
    logic [7:0] sb [$];
    logic [7:0] exp_val;

    memory_1 dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .ready_o (ready),
        .rd_wr_i (rd_wr),
        .addr_i  (addr),
        .rdata_o (rdata),
        .wdata_i (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted request per call; reads queue the value the model expects one edge later.
    task automatic drive(input logic wr, input logic [3:0] a, input logic [7:0] d);
        valid = 1'b1;
        rd_wr = wr;
        addr  = a;
        wdata = d;
        if (wr) mdl[a] = d;
        else    sb.push_back(mdl[a]);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle();
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        rd_wr = 1'b0;
        addr  = '0;
        wdata = '0;
        #23;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b want=0", ready);
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_rdata got=%h want=00", rdata);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got=%b want=1", ready);
        end
    endtask

    task automatic test_fd_wr_fd_rd();
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'(i), 8'h00);
            exp_val = sb.pop_front();
            checks++;
            if (rdata !== exp_val) begin
                errors++;
                $display("[TB] FAIL fd_wr_fd_rd addr=%0d got=%h want=%h", i, rdata, exp_val);
            end
        end
    endtask

    task automatic test_bd_wr_fd_rd();
        for (int i = 0; i < 16; i++) begin
            dut.mem1[i] = 8'(i);
            mdl[i]      = 8'(i);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'(i), 8'h00);
            exp_val = sb.pop_front();
            checks++;
            if (rdata !== exp_val) begin
                errors++;
                $display("[TB] FAIL bd_wr_fd_rd addr=%0d got=%h want=%h", i, rdata, exp_val);
            end
        end
    endtask

    task automatic test_fd_wr_bd_rd();
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 8'hF0 | 8'(i));
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.mem1[i] !== (8'hF0 + 8'(i))) begin
                errors++;
                $display("[TB] FAIL fd_wr_bd_rd addr=%0d got=%h want=%h", i, dut.mem1[i], 8'hF0 + 8'(i));
            end
        end
    endtask

    task automatic test_bd_wr_bd_rd();
        for (int i = 0; i < 16; i++) begin
            mdl[i]      = 8'($urandom);
            dut.mem1[i] = mdl[i];
        end
        for (int c = 0; c < 4; c++) begin
            idle();
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bd_ready cycle=%0d got=%b want=1", c, ready);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.mem1[i] !== mdl[i]) begin
                errors++;
                $display("[TB] FAIL bd_wr_bd_rd addr=%0d got=%h want=%h", i, dut.mem1[i], mdl[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) drive(1'b1, 4'(i), 8'hA0 | 8'(i));
        drive(1'b0, 4'd5, 8'h00);
        exp_val = sb.pop_front();
        checks++;
        if (rdata !== exp_val) begin
            errors++;
            $display("[TB] FAIL mid_pre_read got=%h want=%h", rdata, exp_val);
        end
        // Write in flight when reset hits; must be dropped.
        valid = 1'b1;
        rd_wr = 1'b1;
        addr  = 4'd9;
        wdata = 8'h77;
        #2;
        rst = 1'b1;
`ifdef MEMORY_1_CLR_ON_RST_EN
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
`endif
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_ready got=%b want=0", ready);
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_async_rdata got=%h want=00", rdata);
        end
        @(posedge clk);
        #1;
        addr  = 4'd2;
        wdata = 8'h11;
        @(posedge clk);
        #3;
        rst   = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_release_ready got=%b want=1", ready);
        end
        drive(1'b0, 4'd9, 8'h00);
        exp_val = sb.pop_front();
        checks++;
        if (rdata !== exp_val) begin
            errors++;
            $display("[TB] FAIL mid_dropped_wr9 got=%h want=%h", rdata, exp_val);
        end
        drive(1'b0, 4'd2, 8'h00);
        exp_val = sb.pop_front();
        checks++;
        if (rdata !== exp_val) begin
            errors++;
            $display("[TB] FAIL mid_reset_wr2 got=%h want=%h", rdata, exp_val);
        end
    endtask

    task automatic test_read_after_write();
        drive(1'b1, 4'd3, 8'h5A);
        drive(1'b0, 4'd3, 8'h00);
        exp_val = sb.pop_front();
        checks++;
        if (rdata !== exp_val || rdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL raw_read got=%h want=5a", rdata);
        end
        idle();
        checks++;
        if (rdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL raw_idle_hold got=%h want=5a", rdata);
        end
        drive(1'b1, 4'd3, 8'hC3);
        checks++;
        if (rdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL raw_write_hold got=%h want=5a", rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        for (int n = 0; n < 24; n++) begin
            a = 4'($urandom_range(0, 15));
            drive(1'b1, a, 8'($urandom));
            drive(1'b0, 4'($urandom_range(0, 15)), 8'h00);
            exp_val = sb.pop_front();
            checks++;
            if (rdata !== exp_val) begin
                errors++;
                $display("[TB] FAIL back_to_back n=%0d got=%h want=%h", n, rdata, exp_val);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fd_wr_fd_rd();
        test_bd_wr_fd_rd();
        test_fd_wr_bd_rd();
        test_bd_wr_bd_rd();
        test_reset_mid();
        test_read_after_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
